// File: rtl/digest_byte_serializer.sv
// Unpacks a captured hash digest into a byte stream, most significant byte first.
// Ports: clk, reset (sync, high); digest/digest_valid capture; busy; byte_out/byte_valid/byte_ready stream; done pulse.
module digest_byte_serializer #(
   parameter int DIGEST_BITS = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DIGEST_BITS-1:0] digest,
   input  logic                   digest_valid,
   output logic                   busy,
   output logic [7:0]             byte_out,
   output logic                   byte_valid,
   input  logic                   byte_ready,
   output logic                   done
);
   localparam int NBYTES = DIGEST_BITS / 8;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   if ((DIGEST_BITS % 8) != 0 || DIGEST_BITS < 16) begin : g_bad_width
      $error("DIGEST_BITS must be a multiple of 8 and at least 16");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state, state_nx;
   logic [DIGEST_BITS-1:0] sr, sr_nx;
   logic [CW-1:0]          count, count_nx;
   logic                   done_nx;
   logic                   hs;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sr    <= '0;
         count <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         sr    <= sr_nx;
         count <= count_nx;
         done  <= done_nx;
      end
   end

   // Handshake depends only on registered state plus byte_ready, and only
   // feeds next-state logic, so no combinational ready->valid path exists.
   assign hs = (state == SEND) && byte_ready;

   always_comb begin
      state_nx = state;
      sr_nx    = sr;
      count_nx = count;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (digest_valid) begin
               state_nx = SEND;
               sr_nx    = digest;
               count_nx = '0;
            end
         end
         SEND: begin
            if (hs) begin
               sr_nx = sr << 8;
               // Counter holds at the last index instead of wrapping.
               if (count == LAST) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  count_nx = count + 1'b1;
               end
            end
         end
      endcase
   end

   assign busy       = (state == SEND);
   assign byte_valid = (state == SEND);
   assign byte_out   = sr[DIGEST_BITS-1 -: 8];

endmodule

// File: tb/tb_digest_byte_serializer.sv
// Directed bench for digest_byte_serializer (256-bit and 32-bit instances).
// Drives inputs 1 time unit after posedge, samples on negedge.
module tb_digest_byte_serializer;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [255:0] digest = '0;
   logic         digest_valid = 1'b0;
   logic         busy;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic         byte_ready = 1'b0;
   logic         done;

   logic [31:0]  digest32 = '0;
   logic         dv32 = 1'b0;
   logic         busy32;
   logic [7:0]   bo32;
   logic         bv32;
   logic         rdy32 = 1'b0;
   logic         done32;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   digest_byte_serializer #(.DIGEST_BITS(256)) dut (
      .clk(clk), .reset(reset), .digest(digest),
      .digest_valid(digest_valid), .busy(busy),
      .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .done(done)
   );

   digest_byte_serializer #(.DIGEST_BITS(32)) dut32 (
      .clk(clk), .reset(reset), .digest(digest32),
      .digest_valid(dv32), .busy(busy32),
      .byte_out(bo32), .byte_valid(bv32),
      .byte_ready(rdy32), .done(done32)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] expb(input int mode, input int k);
      if (mode == 0) return 8'(k);
      if (mode == 1) return 8'(31 - k);
      return 8'hAA;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [255:0] d);
      digest = d;
      digest_valid = 1'b1;
      step();
      digest_valid = 1'b0;
   endtask

   // Accept bytes first..n-1; every cycle the current byte must be valid
   // and equal to the expected one, which also covers stall stability.
   task automatic recv(input int first, input int n, input int mode,
                       input bit rnd, input int pulse_at);
      int  k = first;
      int  guard = 0;
      bit  rdy;
      bit  pulsed = 1'b0;
      while (k < n) begin
         rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         byte_ready = rdy;
         @(negedge clk);
         chk("byte_valid", 64'(byte_valid), 64'd1);
         chk("byte_out", 64'(byte_out), 64'(expb(mode, k)));
         chk("busy", 64'(busy), 64'd1);
         chk("done_low", 64'(done), 64'd0);
         if (byte_valid && rdy) k++;
         step();
         if (pulse_at >= 0) begin
            digest_valid = (k == pulse_at) && !pulsed;
            if (digest_valid) begin
               pulsed = 1'b1;
               digest = '1;
            end
         end
         guard++;
         if (guard > 1000) begin
            chk("timeout", 64'd0, 64'd1);
            break;
         end
      end
      digest_valid = (pulse_at >= 0) ? 1'b0 : digest_valid;
   endtask

   task automatic fin_chk();
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd1);
      chk("busy_end", 64'(busy), 64'd0);
      chk("valid_end", 64'(byte_valid), 64'd0);
   endtask

   logic [255:0] seq, rev;

   initial begin
      for (int i = 0; i < 32; i++) begin
         seq[255-8*i -: 8] = 8'(i);
         rev[255-8*i -: 8] = 8'(31 - i);
      end

      // reset state
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_bo", 64'(byte_out), 64'h00);
      chk("rst_bv", 64'(byte_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      step();

      // 1: full-rate stream
      start(seq);
      recv(0, 32, 0, 1'b0, -1);
      fin_chk();
      step();
      @(negedge clk);
      chk("done_once", 64'(done), 64'd0);
      step();

      // 2: random backpressure
      start(seq);
      recv(0, 32, 0, 1'b1, -1);
      fin_chk();
      step();

      // 3: digest_valid while busy is ignored
      start(seq);
      recv(0, 32, 0, 1'b0, 6);
      fin_chk();
      step();

      // 4: level-held digest_valid gives back-to-back transfers
      digest = {32{8'hAA}};
      digest_valid = 1'b1;
      step();
      recv(0, 32, 2, 1'b0, -1);
      fin_chk();
      step();
      digest_valid = 1'b0;
      recv(0, 32, 2, 1'b0, -1);
      fin_chk();
      step();

      // 5: reset while byte 10 is stalled
      start(seq);
      recv(0, 10, 0, 1'b0, -1);
      byte_ready = 1'b0;
      @(negedge clk);
      chk("stall_bo", 64'(byte_out), 64'h0A);
      step();
      @(negedge clk);
      chk("stall_bv", 64'(byte_valid), 64'd1);
      chk("stall_bo2", 64'(byte_out), 64'h0A);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_bv", 64'(byte_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_bo", 64'(byte_out), 64'h00);
      step();
      start(rev);
      recv(0, 32, 1, 1'b0, -1);
      fin_chk();
      step();

      // 6: 32-bit instance
      digest32 = 32'h11223344;
      dv32 = 1'b1;
      step();
      dv32 = 1'b0;
      rdy32 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("d32_bv", 64'(bv32), 64'd1);
         case (k)
            0: chk("d32_b0", 64'(bo32), 64'h11);
            1: chk("d32_b1", 64'(bo32), 64'h22);
            2: chk("d32_b2", 64'(bo32), 64'h33);
            default: chk("d32_b3", 64'(bo32), 64'h44);
         endcase
         step();
      end
      @(negedge clk);
      chk("d32_done", 64'(done32), 64'd1);
      chk("d32_busy", 64'(busy32), 64'd0);
      chk("d32_count", 64'(dut32.count), 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/digest_byte_serializer.md
Name: digest_byte_serializer

Overview:
- Converts a wide hash digest from the Keccak/SHA-3 core into a byte stream for the UART transmit path.
- Performs the reverse of the input-side packing, which assembles bytes into 32-bit words most-significant byte first. This block unpacks the digest in that same order.
- Captures the digest once per hash and then emits it one byte per valid/ready handshake.

Parameters:
- DIGEST_BITS, 256: digest width in bits. Must be a multiple of 8 and at least 16.
- NBYTES, DIGEST_BITS/8: derived value, not overridable. Number of bytes emitted per digest.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- digest  input  DIGEST_BITS  hash result. Sampled only on the capture cycle.
- digest_valid  input  1  digest is available. May be a pulse or a level.
- busy  output  1  a digest is captured and not yet fully emitted.
- byte_out  output  8  current output byte.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  downstream (UART TX) accepts byte_out this cycle.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset: all outputs go to 0 on the clock edge where reset is high: byte_out=0x00, byte_valid=0, busy=0, done=0. The state register goes to IDLE and the byte counter to 0.
- Reset mid-stream: the transfer is aborted and no done pulse is produced. byte_valid=0 from the next cycle.
- The state machine has two states, IDLE and SEND.
- IDLE:
  - If digest_valid=1 at a clock edge, copy digest into a DIGEST_BITS shift register, set count=0 and go to SEND.
  - busy=1 and byte_valid=1 from that edge.
  - byte_out = digest[DIGEST_BITS-1 -: 8], so the first byte is visible one cycle after capture.
- SEND:
  - byte_out always shows the top byte of the shift register.
  - A handshake occurs on any edge where byte_valid=1 and byte_ready=1. On a handshake the register shifts left by 8, and count increments.
  - With no handshake, byte_out and byte_valid hold stable. This is a strict AXI-style rule: byte_valid never drops without a handshake, and the data never changes while stalled.
  - On the handshake where count==NBYTES-1, go to IDLE. On that edge: byte_valid=0, busy=0, done=1 for exactly one cycle.
- byte_ready has no effect while byte_valid=0.
- Byte order: byte k, counting from 0, is digest[DIGEST_BITS-1-8k -: 8].
  - Example with DIGEST_BITS=32 and digest 0x11223344: the output order is 0x11, 0x22, 0x33, 0x44.
- Counter width is clog2(NBYTES); it never wraps inside a transfer.
- Throughput is 1 byte/cycle with byte_ready held high. One digest takes NBYTES cycles from the first byte_valid to the last handshake.
- digest_valid while busy is ignored, with no re-capture and no corruption of the shift register. This includes the cycle of the final handshake.
  - A level-held digest_valid is therefore recaptured on the first edge in IDLE, i.e. the cycle after done.
- After capture, changes on the digest input have no effect.
- byte_out after the final shift holds whatever the shift register contains. It is don't-care while byte_valid=0, but must not be X after reset.
- Purely synchronous; no combinational path from byte_ready to byte_valid or byte_out.

Test Plan:
1. Reset, then DIGEST_BITS=256, digest=0x000102…1F, one-cycle digest_valid, byte_ready=1 constantly -> byte_valid=1 from the cycle after capture. The stream is 0x00, 0x01, …, 0x1F on 32 consecutive cycles. done pulses once in the cycle after 0x1F is accepted, with busy=0 at the same time.
2. Same digest with byte_ready toggling 1,0,0,1,… pseudo-randomly -> bytes are still exactly 0x00…0x1F in order with no duplicates or drops. byte_out is stable and byte_valid stays 1 during every stall.
3. digest_valid pulsed again with digest=0xFF…FF after byte 5 has been accepted -> the stream continues 0x06…0x1F unaffected, and busy stays 1 until the end.
4. digest_valid held high with digest=0xAA…AA -> two back-to-back transfers of 32×0xAA. The second first byte appears 2 cycles after the first transfer's last handshake: one IDLE capture cycle, then SEND.
5. Reset asserted for 1 cycle while byte 10 is stalled (byte_ready=0) -> next cycle byte_valid=0, busy=0, done=0, byte_out=0x00. A new digest 0x1F1E…00 then streams from 0x1F.
6. Parameter DIGEST_BITS=32, digest=0x11223344, byte_ready=1 -> stream 0x11, 0x22, 0x33, 0x44, then done. Counter terminates at 3.
